// File: rtl/fadd16_share_arb.sv
// rtl/fadd16_share_arb.sv - two-requester arbiter sharing one fixed-latency fadd16 pipeline
// Credit-gated issue guarantees every returning result finds room in its response FIFO.
module fadd16_share_arb #(
  parameter int FADD_LAT  = 2,
  parameter int RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [15:0] req0_opa_i,
  input  logic [15:0] req0_opb_i,
  input  logic [2:0]  req0_rm_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [15:0] req1_opa_i,
  input  logic [15:0] req1_opb_i,
  input  logic [2:0]  req1_rm_i,
  output logic        fadd_valid_o,
  output logic [15:0] fadd_opa_o,
  output logic [15:0] fadd_opb_o,
  output logic [2:0]  fadd_rm_o,
  input  logic [15:0] fadd_res_i,
  input  logic [4:0]  fadd_fflags_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [15:0] rsp0_res_o,
  output logic [4:0]  rsp0_fflags_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [15:0] rsp1_res_o,
  output logic [4:0]  rsp1_fflags_o
);

  localparam int PW = (RSP_DEPTH > 2) ? 2 : 1;

  logic [1:0]          w_req_valid;
  logic [1:0]          w_rsp_ready;
  logic [1:0]          w_elig;
  logic [1:0]          w_ready;
  logic [1:0]          w_push;
  logic [1:0]          w_pop;
  logic [15:0]         w_opa [2];
  logic [15:0]         w_opb [2];
  logic [2:0]          w_rm [2];
  logic [3:0]          w_inflight [2];
  logic                w_xfer;
  logic                w_gnt_id;
  logic                w_wr;
  logic                w_wr_id;

  logic                r_prio;
  logic                r_fadd_valid;
  logic                r_iss_id;
  logic [15:0]         r_opa;
  logic [15:0]         r_opb;
  logic [2:0]          r_rm;
  logic [FADD_LAT-1:0] r_sr_v;
  logic [FADD_LAT-1:0] r_sr_id;
  logic [3:0]          r_occ [2];
  logic [PW-1:0]       r_wp [2];
  logic [PW-1:0]       r_rp [2];
  logic [15:0]         r_mem_res [2][RSP_DEPTH];
  logic [4:0]          r_mem_ff [2][RSP_DEPTH];

  assign w_req_valid = {req1_valid_i, req0_valid_i};
  assign w_rsp_ready = {rsp1_ready_i, rsp0_ready_i};
  assign w_opa[0]    = req0_opa_i;
  assign w_opa[1]    = req1_opa_i;
  assign w_opb[0]    = req0_opb_i;
  assign w_opb[1]    = req1_opb_i;
  assign w_rm[0]     = req0_rm_i;
  assign w_rm[1]     = req1_rm_i;

  // Credit consumed = queued results plus ops still travelling through issue reg and pipeline.
  always_comb begin
    w_elig = 2'b00;
    for (int n = 0; n < 2; n++) begin
      w_inflight[n] = (r_fadd_valid && (r_iss_id == 1'(n))) ? 4'd1 : 4'd0;
      for (int k = 0; k < FADD_LAT; k++) begin
        if (r_sr_v[k] && (r_sr_id[k] == 1'(n))) begin
          w_inflight[n] = w_inflight[n] + 4'd1;
        end
      end
      w_elig[n] = w_req_valid[n] && ((r_occ[n] + w_inflight[n]) < 4'(RSP_DEPTH));
    end
  end

  assign w_ready[0] = !rst && w_elig[0] && !(w_elig[1] && r_prio);
  assign w_ready[1] = !rst && w_elig[1] && !(w_elig[0] && !r_prio);
  assign w_xfer     = |w_ready;
  assign w_gnt_id   = w_ready[1];
  assign w_wr       = r_sr_v[FADD_LAT-1];
  assign w_wr_id    = r_sr_id[FADD_LAT-1];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_push[n] = w_wr && (w_wr_id == 1'(n));
      w_pop[n]  = (r_occ[n] != 4'd0) && w_rsp_ready[n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio       <= 1'b0;
      r_fadd_valid <= 1'b0;
      r_iss_id     <= 1'b0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_rm         <= '0;
      r_sr_v       <= '0;
      r_sr_id      <= '0;
    end else begin
      r_fadd_valid <= w_xfer;
      if (w_xfer) begin
        r_iss_id <= w_gnt_id;
        r_opa    <= w_opa[w_gnt_id];
        r_opb    <= w_opb[w_gnt_id];
        r_rm     <= w_rm[w_gnt_id];
        r_prio   <= ~w_gnt_id;
      end
      r_sr_v[0]  <= r_fadd_valid;
      r_sr_id[0] <= r_iss_id;
      for (int k = 1; k < FADD_LAT; k++) begin
        r_sr_v[k]  <= r_sr_v[k-1];
        r_sr_id[k] <= r_sr_id[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        r_occ[n] <= 4'd0;
        r_wp[n]  <= '0;
        r_rp[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        r_occ[n] <= r_occ[n] + {3'b000, w_push[n]} - {3'b000, w_pop[n]};
        if (w_push[n]) begin
          r_wp[n] <= (r_wp[n] == PW'(RSP_DEPTH - 1)) ? '0 : r_wp[n] + PW'(1);
        end
        if (w_pop[n]) begin
          r_rp[n] <= (r_rp[n] == PW'(RSP_DEPTH - 1)) ? '0 : r_rp[n] + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (w_push[n]) begin
        r_mem_res[n][r_wp[n]] <= fadd_res_i;
        r_mem_ff[n][r_wp[n]]  <= fadd_fflags_i;
      end
    end
  end

  assign req0_ready_o  = w_ready[0];
  assign req1_ready_o  = w_ready[1];
  assign fadd_valid_o  = r_fadd_valid;
  assign fadd_opa_o    = r_opa;
  assign fadd_opb_o    = r_opb;
  assign fadd_rm_o     = r_rm;
  assign rsp0_valid_o  = (r_occ[0] != 4'd0);
  assign rsp1_valid_o  = (r_occ[1] != 4'd0);
  assign rsp0_res_o    = rsp0_valid_o ? r_mem_res[0][r_rp[0]] : 16'h0000;
  assign rsp0_fflags_o = rsp0_valid_o ? r_mem_ff[0][r_rp[0]]  : 5'h00;
  assign rsp1_res_o    = rsp1_valid_o ? r_mem_res[1][r_rp[1]] : 16'h0000;
  assign rsp1_fflags_o = rsp1_valid_o ? r_mem_ff[1][r_rp[1]]  : 5'h00;

endmodule

// File: tb/tb_fadd16_share_arb.sv
// tb/tb_fadd16_share_arb.sv - directed and random checks of fadd16_share_arb against a credit/queue model
module tb_fadd16_share_arb;
  localparam int LAT   = 2;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [15:0] req0_opa_i, req0_opb_i, req1_opa_i, req1_opb_i;
  logic [2:0]  req0_rm_i, req1_rm_i;
  logic        fadd_valid_o;
  logic [15:0] fadd_opa_o, fadd_opb_o;
  logic [2:0]  fadd_rm_o;
  logic [15:0] fadd_res_i = 16'hDEAD;
  logic [4:0]  fadd_fflags_i = 5'h1F;
  logic        rsp0_valid_o, rsp1_valid_o;
  logic        rsp0_ready_i, rsp1_ready_i;
  logic [15:0] rsp0_res_o, rsp1_res_o;
  logic [4:0]  rsp0_fflags_o, rsp1_fflags_o;

  fadd16_share_arb #(.FADD_LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_opa_i(req0_opa_i),
    .req0_opb_i(req0_opb_i), .req0_rm_i(req0_rm_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_opa_i(req1_opa_i),
    .req1_opb_i(req1_opb_i), .req1_rm_i(req1_rm_i),
    .fadd_valid_o(fadd_valid_o), .fadd_opa_o(fadd_opa_o), .fadd_opb_o(fadd_opb_o),
    .fadd_rm_o(fadd_rm_o), .fadd_res_i(fadd_res_i), .fadd_fflags_i(fadd_fflags_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i), .rsp0_res_o(rsp0_res_o),
    .rsp0_fflags_o(rsp0_fflags_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i), .rsp1_res_o(rsp1_res_o),
    .rsp1_fflags_o(rsp1_fflags_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Truncating fp16 add for positive normal operands; returns {fflags, result}, NX in bit 0.
  function automatic logic [20:0] fadd_model(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] a, b;
    logic [4:0]  e;
    logic [11:0] ma, mb, sum;
    logic        nx;
    int          d;
    if (x[14:0] >= y[14:0]) begin a = x; b = y; end
    else begin a = y; b = x; end
    e  = a[14:10];
    d  = int'(a[14:10]) - int'(b[14:10]);
    ma = {2'b01, a[9:0]};
    mb = {2'b01, b[9:0]};
    if (d > 11) begin
      nx = 1'b1;
      mb = 12'd0;
    end else begin
      nx = |(mb & ((12'd1 << d) - 12'd1));
      mb = mb >> d;
    end
    sum = ma + mb;
    if (sum[11]) begin
      nx  = nx | sum[0];
      sum = sum >> 1;
      e   = e + 5'd1;
    end
    return {4'b0000, nx, 1'b0, e, sum[9:0]};
  endfunction

  // Model state: expected responses per requester and outstanding ops (transfer until pop).
  logic [35:0] hist [0:LAT];
  logic [20:0] expq0[$];
  logic [20:0] expq1[$];
  int          outst [2];
  int          xfer_cnt [2];
  int          last_gnt;
  logic        exp_iss_v;
  logic [34:0] exp_iss;
  logic        e0, e1, exp_r0, exp_r1;

  initial begin
    for (int k = 0; k <= LAT; k++) hist[k] = '0;
    outst[0] = 0; outst[1] = 0;
    xfer_cnt[0] = 0; xfer_cnt[1] = 0;
    last_gnt = 1; exp_iss_v = 1'b0; exp_iss = '0;
  end

  always @(negedge clk) begin
    #3;
    for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = {fadd_valid_o, fadd_opa_o, fadd_opb_o, fadd_rm_o};
    if (hist[LAT][35]) {fadd_fflags_i, fadd_res_i} = fadd_model(hist[LAT][34:19], hist[LAT][18:3]);
    else begin
      fadd_res_i    = 16'hDEAD;
      fadd_fflags_i = 5'h1F;
    end
    if (rst) begin
      check({req0_ready_o, req1_ready_o, fadd_valid_o, rsp0_valid_o, rsp1_valid_o} == 5'b0 &&
            {fadd_opa_o, fadd_opb_o, fadd_rm_o} == 35'd0 &&
            {rsp0_res_o, rsp0_fflags_o, rsp1_res_o, rsp1_fflags_o} == 42'd0,
            "reset_outputs", {req0_ready_o, req1_ready_o, fadd_valid_o, rsp0_valid_o, rsp1_valid_o}, 0);
      expq0.delete(); expq1.delete();
      outst[0] = 0; outst[1] = 0;
      last_gnt = 1; exp_iss_v = 1'b0; exp_iss = '0;
    end else begin
      e0 = req0_valid_i && (outst[0] < DEPTH);
      e1 = req1_valid_i && (outst[1] < DEPTH);
      exp_r0 = e0 && !(e1 && last_gnt == 0);
      exp_r1 = e1 && !(e0 && last_gnt == 1);
      check({req1_ready_o, req0_ready_o} === {exp_r1, exp_r0}, "grant",
            {req1_ready_o, req0_ready_o}, {exp_r1, exp_r0});
      check(fadd_valid_o === exp_iss_v, "issue_valid", fadd_valid_o, exp_iss_v);
      check({fadd_opa_o, fadd_opb_o, fadd_rm_o} === exp_iss, "issue_ops",
            {fadd_opa_o, fadd_opb_o, fadd_rm_o}, exp_iss);
      if (rsp0_valid_o) begin
        check(expq0.size() != 0, "rsp0_spurious", rsp0_res_o, 0);
        if (expq0.size() != 0) begin
          check({rsp0_fflags_o, rsp0_res_o} === expq0[0], "rsp0_data", {rsp0_fflags_o, rsp0_res_o}, expq0[0]);
          if (rsp0_ready_i) begin
            void'(expq0.pop_front());
            outst[0]--;
          end
        end
      end
      if (rsp1_valid_o) begin
        check(expq1.size() != 0, "rsp1_spurious", rsp1_res_o, 0);
        if (expq1.size() != 0) begin
          check({rsp1_fflags_o, rsp1_res_o} === expq1[0], "rsp1_data", {rsp1_fflags_o, rsp1_res_o}, expq1[0]);
          if (rsp1_ready_i) begin
            void'(expq1.pop_front());
            outst[1]--;
          end
        end
      end
      exp_iss_v = 1'b0;
      if (req0_valid_i && req0_ready_o) begin
        expq0.push_back(fadd_model(req0_opa_i, req0_opb_i));
        outst[0]++; xfer_cnt[0]++; last_gnt = 0;
        exp_iss_v = 1'b1; exp_iss = {req0_opa_i, req0_opb_i, req0_rm_i};
      end else if (req1_valid_i && req1_ready_o) begin
        expq1.push_back(fadd_model(req1_opa_i, req1_opb_i));
        outst[1]++; xfer_cnt[1]++; last_gnt = 1;
        exp_iss_v = 1'b1; exp_iss = {req1_opa_i, req1_opb_i, req1_rm_i};
      end
    end
  end

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  function automatic logic [15:0] rand_op();
    return {1'b0, 5'($urandom_range(1, 28)), 10'($urandom)};
  endfunction

  task automatic new_ops();
    req0_opa_i = req0_valid_i ? rand_op() : 16'hxxxx;
    req0_opb_i = req0_valid_i ? rand_op() : 16'hxxxx;
    req0_rm_i  = 3'($urandom);
    req1_opa_i = req1_valid_i ? rand_op() : 16'hxxxx;
    req1_opb_i = req1_valid_i ? rand_op() : 16'hxxxx;
    req1_rm_i  = 3'($urandom);
  endtask

  task automatic idle_drain(input int n);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    new_ops();
    repeat (n) next();
  endtask

  logic [15:0] pa, pb;
  logic [20:0] pm;
  int          g, d0, d1, bad;

  initial begin
    rst = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    new_ops();
    next(); next();

    pa = 16'h3C00; pb = 16'h4000; pm = fadd_model(pa, pb);
    check(pm == 21'h004200, "model_1p2", pm, 21'h004200);
    pa = 16'h3C00; pb = 16'h3C00; pm = fadd_model(pa, pb);
    check(pm == 21'h004000, "model_1p1", pm, 21'h004000);
    pa = 16'h3C01; pb = 16'h3C00; pm = fadd_model(pa, pb);
    check(pm == 21'h014000, "model_inexact", pm, 21'h014000);

    rst = 1'b0;
    next();
    // single request: transfer in cycle 0, issue cycle 1, response visible cycle 4
    req0_valid_i = 1'b1; req0_opa_i = 16'h3C00; req0_opb_i = 16'h4000; req0_rm_i = 3'd0;
    settle();
    check(req0_ready_o == 1'b1, "single_ready", req0_ready_o, 1);
    next();
    req0_valid_i = 1'b0; req0_opa_i = 16'hxxxx; req0_opb_i = 16'hxxxx;
    settle();
    check(fadd_valid_o == 1'b1 && fadd_opa_o == 16'h3C00 && fadd_opb_o == 16'h4000,
          "single_issue", {fadd_valid_o, fadd_opa_o, fadd_opb_o}, {1'b1, 16'h3C00, 16'h4000});
    next(); next();
    settle();
    check(rsp0_valid_o == 1'b0, "single_not_yet", rsp0_valid_o, 0);
    next();
    settle();
    check(rsp0_valid_o == 1'b1 && rsp0_res_o == 16'h4200, "single_rsp",
          {rsp0_valid_o, rsp0_res_o}, {1'b1, 16'h4200});
    next();
    idle_drain(6);

    // contention after reset: 0,1,0,1
    rst = 1'b1; next(); rst = 1'b0;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1; new_ops();
    for (int i = 0; i < 4; i++) begin
      settle();
      g = req1_ready_o ? 1 : (req0_ready_o ? 0 : -1);
      check(g == (i % 2), "alternate", g, i % 2);
      next();
      new_ops();
    end
    repeat (16) begin next(); new_ops(); end
    idle_drain(10);

    // backpressure on requester 1
    req0_valid_i = 1'b1; req1_valid_i = 1'b1; rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b0;
    d1 = xfer_cnt[1];
    repeat (10) begin new_ops(); next(); end
    d0 = xfer_cnt[0]; bad = 0;
    for (int i = 0; i < 10; i++) begin
      new_ops(); settle();
      if (req1_ready_o) bad++;
      next();
    end
    check(xfer_cnt[1] - d1 == DEPTH, "bp_req1_count", xfer_cnt[1] - d1, DEPTH);
    check(bad == 0, "bp_req1_blocked", bad, 0);
    check(xfer_cnt[0] - d0 >= 4, "bp_req0_flows", xfer_cnt[0] - d0, 4);

    // credit return: one pop frees one slot for the next cycle
    req0_valid_i = 1'b0; rsp1_ready_i = 1'b1; new_ops();
    settle();
    check(rsp1_valid_o == 1'b1 && req1_ready_o == 1'b0, "cr_pop_cycle",
          {rsp1_valid_o, req1_ready_o}, 2'b10);
    next();
    rsp1_ready_i = 1'b0;
    settle();
    check(req1_ready_o == 1'b1, "cr_ready_next", req1_ready_o, 1);
    next();
    idle_drain(12);

    // reset with two ops in flight
    req0_valid_i = 1'b1; req1_valid_i = 1'b1; new_ops();
    next(); new_ops(); next();
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; new_ops(); rst = 1'b1;
    next();
    rst = 1'b0; bad = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (rsp0_valid_o || rsp1_valid_o) bad++;
      next();
    end
    check(bad == 0, "rst_no_rsp", bad, 0);
    req0_valid_i = 1'b1; req1_valid_i = 1'b1; rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    new_ops();
    d0 = xfer_cnt[0]; d1 = xfer_cnt[1];
    settle();
    check(req0_ready_o == 1'b1 && req1_ready_o == 1'b0, "rst_first_winner",
          {req1_ready_o, req0_ready_o}, 2'b01);
    repeat (10) begin next(); new_ops(); end
    check(xfer_cnt[0] - d0 == DEPTH, "rst_credit0", xfer_cnt[0] - d0, DEPTH);
    check(xfer_cnt[1] - d1 == DEPTH, "rst_credit1", xfer_cnt[1] - d1, DEPTH);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      next();
      req0_valid_i = ($urandom_range(0, 99) < 60);
      req1_valid_i = ($urandom_range(0, 99) < 60);
      rsp0_ready_i = ($urandom_range(0, 99) < 70);
      rsp1_ready_i = ($urandom_range(0, 99) < 70);
      new_ops();
    end
    next();
    idle_drain(20);
    settle();
    check(expq0.size() == 0 && expq1.size() == 0 && outst[0] == 0 && outst[1] == 0,
          "drain_empty", expq0.size() + expq1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
